// File: rtl/irda_tx_sched.sv
// Round-robin command scheduler for the IR transmitter. It paces each issue so that
// irda_out never sees Iin_vld while a frame or its guard gap is in progress.
module irda_tx_sched #(
  parameter int unsigned DIV    = 50,
  parameter int unsigned FRA    = 6,
  parameter int unsigned GAP    = 50,
  parameter int unsigned REPEAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  req,
  input  logic [11:0] cmd,
  output logic [3:0]  tx_cmd,
  output logic        tx_vld,
  output logic        busy,
  output logic [1:0]  gnt_id,
  output logic [2:0]  done,
  output logic [2:0]  drop,
  output logic [2:0]  pend
);

  localparam int unsigned NREQ  = 3;
  localparam int unsigned FRAME = DIV * FRA;
  localparam int unsigned CNT_W = $clog2(FRAME) + 1;
  localparam int unsigned RPT_W = $clog2(REPEAT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RPT_W-1:0] rpt;
  logic [1:0]       last;
  logic [3:0]       slot_cmd [NREQ];

  logic [3:0]       pend_x;
  logic [1:0]       cand;
  logic             found;
  logic [1:0]       sel_c;
  logic             grant_c;
  logic [NREQ-1:0]  take_c;
  logic             last_rep_c;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search starting just after the last granted requester
  always_comb begin
    pend_x  = {1'b0, pend};
    cand    = nxt(last);
    found   = 1'b0;
    sel_c   = '0;
    for (int k = 0; k < 3; k++) begin
      if (!found && pend_x[cand]) begin
        found = 1'b1;
        sel_c = cand;
      end
      cand = nxt(cand);
    end
    grant_c    = found && en && (state == S_IDLE);
    take_c     = grant_c ? (3'b001 << sel_c) : 3'b000;
    last_rep_c = (rpt == RPT_W'(REPEAT - 1));
  end

  // Per-requester slots; a reload in the grant cycle refills instead of dropping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      drop <= '0;
      for (int i = 0; i < NREQ; i++) slot_cmd[i] <= '0;
    end else begin
      drop <= '0;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (!pend[i] || take_c[i]) begin
            slot_cmd[i] <= cmd[4*i +: 4];
            pend[i]     <= 1'b1;
          end else begin
            drop[i] <= 1'b1;
          end
        end else if (take_c[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Issue sequencer: SEND -> WAIT (frame time) -> GAP, repeated REPEAT times
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rpt    <= '0;
      last   <= 2'd2;
      gnt_id <= '0;
      tx_cmd <= '0;
      tx_vld <= 1'b0;
      busy   <= 1'b0;
      done   <= '0;
    end else begin
      tx_vld <= 1'b0;
      done   <= '0;
      case (state)
        S_IDLE: begin
          if (grant_c) begin
            state  <= S_SEND;
            tx_vld <= 1'b1;
            tx_cmd <= slot_cmd[sel_c];
            gnt_id <= sel_c;
            last   <= sel_c;
            busy   <= 1'b1;
          end
        end
        S_SEND: begin
          state <= S_WAIT;
          cnt   <= CNT_W'(FRAME - 1);
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_GAP;
            cnt   <= CNT_W'(GAP - 1);
            if (GAP == 1 && last_rep_c) done <= 3'b001 << gnt_id;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            if (!last_rep_c) begin
              rpt    <= rpt + RPT_W'(1);
              state  <= S_SEND;
              tx_vld <= 1'b1;
            end else begin
              rpt   <= '0;
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
            // done lands in the final GAP cycle so a new grant can follow immediately
            if (cnt == CNT_W'(1) && last_rep_c) done <= 3'b001 << gnt_id;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irda_tx_sched.sv
// Bench for irda_tx_sched: a job-timeline reference model compared every cycle, plus
// directed scenarios with hand-computed timing and ordering expectations.
module tb_irda_tx_sched;

  localparam int DIV    = 50;
  localparam int FRA    = 6;
  localparam int GAP    = 50;
  localparam int REPEAT = 2;
  localparam int P      = 1 + DIV * FRA + GAP;
  localparam int SVC    = REPEAT * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  req = '0;
  logic [11:0] cmd = '0;
  logic [3:0]  tx_cmd;
  logic        tx_vld;
  logic        busy;
  logic [1:0]  gnt_id;
  logic [2:0]  done;
  logic [2:0]  drop;
  logic [2:0]  pend;

  irda_tx_sched #(.DIV(DIV), .FRA(FRA), .GAP(GAP), .REPEAT(REPEAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .cmd(cmd),
    .tx_cmd(tx_cmd), .tx_vld(tx_vld), .busy(busy), .gnt_id(gnt_id),
    .done(done), .drop(drop), .pend(pend)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int n       = 0;

  // Model: slot contents plus the grant cycle of the job in service
  logic [2:0] m_pend;
  logic [3:0] m_cmd [3];
  int         m_last;
  int         m_gnt;
  logic [3:0] m_txcmd;
  int         job_g;
  logic [2:0] exp_drop;

  int vq[$];
  int vcmd[$];
  int vgnt[$];
  int dq[$];
  int drop1;
  int last_vld;

  function void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function void clear_logs();
    vq.delete(); vcmd.delete(); vgnt.delete(); dq.delete();
    drop1 = 0;
  endfunction

  function void model_reset();
    m_pend = '0; m_last = 2; m_gnt = 0; m_txcmd = '0;
    job_g = -1; exp_drop = '0; last_vld = -1;
    for (int i = 0; i < 3; i++) m_cmd[i] = '0;
  endfunction

  // Advance the model across the edge that ends cycle n
  function void model_step();
    int sel;
    bit idle;
    sel  = -1;
    idle = (job_g < 0) || (n > job_g + SVC);
    if (idle && en && (m_pend != 3'b000)) begin
      for (int k = 1; k <= 3; k++)
        if (sel < 0 && m_pend[(m_last + k) % 3]) sel = (m_last + k) % 3;
      job_g   = n;
      m_txcmd = m_cmd[sel];
      m_gnt   = sel;
      m_last  = sel;
    end
    exp_drop = '0;
    for (int i = 0; i < 3; i++) begin
      if (req[i]) begin
        if (!m_pend[i] || sel == i) begin
          m_cmd[i]  = cmd[4*i +: 4];
          m_pend[i] = 1'b1;
        end else begin
          exp_drop[i] = 1'b1;
        end
      end else if (sel == i) begin
        m_pend[i] = 1'b0;
      end
    end
  endfunction

  function void compare();
    logic [16:0] act, exp;
    logic        ev, eb;
    logic [2:0]  ed;
    int          k;
    ev = 1'b0; eb = 1'b0; ed = '0;
    if (job_g >= 0) begin
      k = n - job_g - 1;
      if (k >= 0 && k < SVC) begin
        eb = 1'b1;
        if (k % P == 0) ev = 1'b1;
      end
      if (n == job_g + SVC) ed = 3'b001 << m_gnt;
    end
    exp = {m_txcmd, ev, eb, 2'(m_gnt), ed, exp_drop, m_pend};
    act = {tx_cmd, tx_vld, busy, gnt_id, done, drop, pend};
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs cycle %0d (cmd,vld,busy,gnt,done,drop,pend): got %h expected %h",
               n, act, exp);
    end
    if (tx_vld === 1'b1) begin
      if (last_vld >= 0) begin
        vectors++;
        if (n - last_vld < P) begin
          errors++;
          $display("FAIL vld_spacing: got gap %0d expected >= %0d", n - last_vld, P);
        end
      end
      last_vld = n;
      vq.push_back(n); vcmd.push_back(int'(tx_cmd)); vgnt.push_back(int'(gnt_id));
    end
    if (done !== 3'b000) dq.push_back(n);
    if (drop[1] === 1'b1) drop1++;
  endfunction

  task cyc(input logic [2:0] r, input logic [11:0] c, input logic e);
    req = r; cmd = c; en = e;
    model_step();
    @(posedge clk); #1;
    n++;
    compare();
  endtask

  task idle(input int cycles, input logic e);
    repeat (cycles) cyc(3'b000, 12'h000, e);
  endtask

  task do_reset();
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_async", int'({tx_cmd, tx_vld, busy, gnt_id, done, drop, pend}), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n = 0;
    compare();
  endtask

  initial begin
    int t;
    int e_cyc;
    int rst_at;
    logic en_r;
    logic [2:0] r;

    model_reset();
    clear_logs();
    #2;
    do_reset();

    // Single request: latency 2, repeat spacing 351, done 701 cycles after first issue
    clear_logs();
    t = n;
    cyc(3'b001, 12'h00A, 1'b1);
    idle(SVC + 20, 1'b1);
    chk("single_vld_count", vq.size(), 2);
    chk("single_done_count", dq.size(), 1);
    if (vq.size() == 2 && dq.size() == 1) begin
      chk("single_latency", vq[0] - t, 2);
      chk("single_cmd", vcmd[0], 10);
      chk("single_rep_gap", vq[1] - vq[0], 351);
      chk("single_done", dq[0] - vq[0], 701);
    end

    // Round-robin from reset, then again continuing from requester 2
    do_reset();
    clear_logs();
    cyc(3'b111, 12'h321, 1'b1);
    idle(3 * SVC + 5, 1'b1);
    chk("rr3_count", vq.size(), 6);
    if (vq.size() == 6) begin
      chk("rr3_order", vgnt[0] * 100 + vgnt[2] * 10 + vgnt[4], 12);
      chk("rr3_cmds", vcmd[0] * 100 + vcmd[2] * 10 + vcmd[4], 123);
    end
    clear_logs();
    cyc(3'b011, 12'h054, 1'b1);
    idle(2 * SVC + 5, 1'b1);
    chk("rr2_count", vq.size(), 4);
    if (vq.size() == 4) begin
      chk("rr2_order", vgnt[0] * 10 + vgnt[2], 1);
      chk("rr2_cmds", vcmd[0] * 10 + vcmd[2], 45);
    end

    // Drops while slot 1 waits, then a reload in slot 1's own grant cycle
    do_reset();
    clear_logs();
    cyc(3'b001, 12'h005, 1'b1);
    cyc(3'b010, 12'h060, 1'b1);
    idle(5, 1'b1);
    cyc(3'b010, 12'h070, 1'b1);
    idle(5, 1'b1);
    cyc(3'b010, 12'h070, 1'b1);
    for (int i = 0; i < SVC + 10; i++) begin
      if (dq.size() > 0) break;
      cyc(3'b000, 12'h000, 1'b1);
    end
    chk("drop_done_seen", dq.size(), 1);
    cyc(3'b000, 12'h000, 1'b1);
    cyc(3'b010, 12'h080, 1'b1);
    idle(2 * SVC + 10, 1'b1);
    chk("drop_count", drop1, 2);
    chk("reload_count", vq.size(), 6);
    if (vq.size() == 6)
      chk("reload_cmds", vcmd[0] * 100 + vcmd[2] * 10 + vcmd[4], 568);

    // Enable gating: nothing issues while en is low; dropping en mid-WAIT still completes
    do_reset();
    clear_logs();
    cyc(3'b100, 12'h900, 1'b0);
    idle(20, 1'b0);
    chk("en_gate_novld", vq.size(), 0);
    e_cyc = n;
    cyc(3'b000, 12'h000, 1'b1);
    idle(10, 1'b1);
    idle(SVC, 1'b0);
    chk("en_reps", vq.size(), 2);
    chk("en_done", dq.size(), 1);
    if (vq.size() > 0) chk("en_latency", vq[0] - e_cyc, 1);

    // Reset during WAIT of the first repetition
    do_reset();
    clear_logs();
    cyc(3'b001, 12'h00C, 1'b1);
    idle(100, 1'b1);
    do_reset();
    clear_logs();
    idle(SVC + 10, 1'b1);
    chk("rst_no_done", dq.size(), 0);
    chk("rst_no_vld", vq.size(), 0);
    clear_logs();
    cyc(3'b111, 12'hDEF, 1'b1);
    idle(5, 1'b1);
    chk("rst_fresh_vld", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("rst_fresh_gnt", vgnt[0], 0);
      chk("rst_fresh_cmd", vcmd[0], 15);
    end

    // Random traffic with occasional enable toggles and one reset
    en_r   = 1'b1;
    rst_at = $urandom_range(25000, 5000);
    for (int i = 0; i < 30000; i++) begin
      for (int b = 0; b < 3; b++) r[b] = ($urandom_range(299, 0) == 0);
      if ($urandom_range(499, 0) == 0) en_r = ~en_r;
      if (i == rst_at) do_reset();
      cyc(r, 12'($urandom), en_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
